id_ex_ctrl_stage: RTL

//  ID/EX pipeline stage for the control path. Sits directly downstream of the opcode decoder (Controller).
//  - Registers decoded control and register indices into EX.
//  - Detects load-use hazards; stalls IF/ID and inserts bubbles.
//  - Applies branch/jump flushes.
//  - Sequences HALT: drains the pipeline, then freezes the core.

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/load_use_detect.sv | 38 +++
 rtl/id_ex_ctrl_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the ID/EX control stage.
//   alu_op_t  : ALU operation class produced by the decoder.
//   halt_st_t : HALT sequencing state (RUN -> DRAIN -> HALTED).
//   ctrl_t    : the decoded control bits carried from ID into EX.
//   CTRL_BUBBLE : control value of an inserted bubble (all zero).
package pipeline_pkg;

  typedef enum logic [1:0] {
    ALU_LDST = 2'b00,
    ALU_BR   = 2'b01,
    ALU_RI   = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_st_t;

  typedef struct packed {
    logic    halt;
    logic    jump;
    logic    jumpreg;
    logic    alusrc;
    logic    memtoreg;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    branch;
    alu_op_t aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// A load sitting in EX whose destination is read by the instruction in ID
// forces one bubble. x0 is never a real dependency.
// Ports:
//   id_jump, id_jumpreg, id_alusrc, id_memwrite : ID decoder bits that tell
//                                                 which source fields are read
//   id_rs1, id_rs2                              : ID source register fields
//   ex_memread, ex_rd                           : load indicator / dest in EX
//   load_use                                    : hazard present this cycle
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_jump,
  input  logic              id_jumpreg,
  input  logic              id_alusrc,
  input  logic              id_memwrite,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  logic rs1_used;
  logic rs2_used;

  // jal has no rs1 operand; stores read rs2 even though the ALU takes the
  // immediate, so memwrite re-enables the rs2 comparison.
  assign rs1_used = !(id_jump && !id_jumpreg);
  assign rs2_used = !id_alusrc || id_memwrite;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((rs1_used && (id_rs1 == ex_rd)) ||
                     (rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX pipeline register for the control path, with load-use stall,
// branch/jump flush and HALT drain sequencing.
// Optional build macro: ID_EX_PERF_EN adds saturating stall/flush counters.
// Ports:
//   clk, reset       : rising-edge clock, synchronous active-low reset
//   id_*             : decoder outputs and register fields of the ID instr
//   ex_flush         : taken branch/jump in EX, squash the ID instruction
//   ex_*             : registered copies of id_* (bubble = all zero)
//   stall            : hold PC and IF/ID this cycle (combinational)
//   halted           : core frozen, sticky until reset
//   state_dbg        : current HALT sequencing state
//   stall_cnt, flush_cnt : perf counters (ID_EX_PERF_EN only)
// Handshake: there is no valid/ready pair here; stall is the only
// back-pressure and is valid in the same cycle it is computed, upstream must
// hold IF/ID whenever it is 1.
module id_ex_ctrl_stage
  import pipeline_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 3
`ifdef ID_EX_PERF_EN
  , parameter int CNT_W      = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_halt,
  input  logic              id_jump,
  input  logic              id_jumpreg,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic [1:0]        id_aluop,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              ex_flush,
  output logic              ex_halt,
  output logic              ex_jump,
  output logic              ex_jumpreg,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic [1:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              stall,
  output logic              halted,
  output halt_st_t          state_dbg
`ifdef ID_EX_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_t             id_ctrl;
  ctrl_t             ex_ctrl;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [2:0]        ex_funct3_q;

  halt_st_t          state, next_state;
  logic [DC_W-1:0]   drain_cnt, next_drain_cnt;

  logic              load_use;
  logic              take_id;    // EX captures ID this edge, else bubble
  logic              lu_stall;   // stall caused by a load-use hazard in RUN
  logic              run_flush;  // flush honoured in RUN

  assign id_ctrl = '{halt:     id_halt,
                     jump:     id_jump,
                     jumpreg:  id_jumpreg,
                     alusrc:   id_alusrc,
                     memtoreg: id_memtoreg,
                     regwrite: id_regwrite,
                     memread:  id_memread,
                     memwrite: id_memwrite,
                     branch:   id_branch,
                     aluop:    alu_op_t'(id_aluop)};

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .id_jump     (id_jump),
    .id_jumpreg  (id_jumpreg),
    .id_alusrc   (id_alusrc),
    .id_memwrite (id_memwrite),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_memread  (ex_ctrl.memread),
    .ex_rd       (ex_rd_q),
    .load_use    (load_use)
  );

  // Next-state and stall decode. A HALT already in EX outranks everything:
  // from that cycle on nothing new may issue.
  always_comb begin
    next_state     = state;
    next_drain_cnt = drain_cnt;
    take_id        = 1'b0;
    stall          = 1'b0;
    lu_stall       = 1'b0;
    run_flush      = 1'b0;
    case (state)
      RUN: begin
        if (ex_ctrl.halt) begin
          stall = 1'b1;
          if (DRAIN_CYCLES == 0) begin
            next_state = HALTED;
          end else begin
            next_state     = DRAIN;
            next_drain_cnt = DC_W'(DRAIN_CYCLES - 1);
          end
        end else if (ex_flush) begin
          run_flush = 1'b1;
        end else if (load_use) begin
          stall    = 1'b1;
          lu_stall = 1'b1;
        end else begin
          take_id = 1'b1;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (drain_cnt == '0) begin
          next_state = HALTED;
        end else begin
          next_drain_cnt = drain_cnt - DC_W'(1);
        end
      end
      HALTED: begin
        stall = 1'b1;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      drain_cnt   <= '0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      ex_funct3_q <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain_cnt;
      if (take_id) begin
        ex_ctrl     <= id_ctrl;
        ex_rs1_q    <= id_rs1;
        ex_rs2_q    <= id_rs2;
        ex_rd_q     <= id_rd;
        ex_funct3_q <= id_funct3;
      end else begin
        ex_ctrl     <= CTRL_BUBBLE;
        ex_rs1_q    <= '0;
        ex_rs2_q    <= '0;
        ex_rd_q     <= '0;
        ex_funct3_q <= '0;
      end
    end
  end

`ifdef ID_EX_PERF_EN
  // Counters only advance in RUN, so they stop by themselves once halted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (run_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

  assign ex_halt     = ex_ctrl.halt;
  assign ex_jump     = ex_ctrl.jump;
  assign ex_jumpreg  = ex_ctrl.jumpreg;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_aluop    = ex_ctrl.aluop;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_funct3   = ex_funct3_q;
  assign halted      = (state == HALTED);
  assign state_dbg   = state;

endmodule
